// File: rtl/video_timing.sv
// Pixel-clock divider plus horizontal/vertical raster counters with registered
// sync, visible-area and end-of-visible-frame strobes.
module video_timing #(
   parameter int CLK_DIV   = 2,
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       CLK,
   input  logic       RESET,
   output logic       PIXEL_TICK,
   output logic [9:0] PIXEL_X,
   output logic [9:0] PIXEL_Y,
   output logic       VISIBLE,
   output logic       HSYNC,
   output logic       VSYNC,
   output logic       FRAME_RENDERED
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);
   localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic [3:0] div_q, div_d;
   logic [9:0] x_q, x_d;
   logic [9:0] y_q, y_d;
   logic       visible_q, hsync_q, vsync_q, frame_q;
   logic       tick;

   always_comb begin
      tick  = (div_q == DIV_LAST);
      div_d = div_q + 4'd1;
      x_d   = x_q;
      y_d   = y_q;
      if (tick) begin
         div_d = 4'd0;
         if (x_q == H_LAST) begin
            x_d = 10'd0;
            if (y_q == V_LAST) begin
               y_d = 10'd0;
            end else begin
               y_d = y_q + 10'd1;
            end
         end else begin
            x_d = x_q + 10'd1;
         end
      end else begin
         div_d = div_q + 4'd1;
      end
   end

   // Status flags are derived from the next counter values so they line up
   // with PIXEL_X/PIXEL_Y on the same edge.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         div_q     <= 4'd0;
         x_q       <= 10'd0;
         y_q       <= 10'd0;
         visible_q <= 1'b0;
         hsync_q   <= 1'b1;
         vsync_q   <= 1'b1;
         frame_q   <= 1'b0;
      end else begin
         div_q     <= div_d;
         x_q       <= x_d;
         y_q       <= y_d;
         visible_q <= (x_d < H_VIS) && (y_d < V_VIS);
         hsync_q   <= !((x_d >= HS_FIRST) && (x_d <= HS_LAST));
         vsync_q   <= !((y_d >= VS_FIRST) && (y_d <= VS_LAST));
         frame_q   <= tick && (x_q == H_LAST) && (y_q == V_VIS_LAST);
      end
   end

   // With CLK_DIV=1 the divider sits at its last value, so reset must mask the tick.
   assign PIXEL_TICK     = tick & ~RESET;
   assign PIXEL_X        = x_q;
   assign PIXEL_Y        = y_q;
   assign VISIBLE        = visible_q;
   assign HSYNC          = hsync_q;
   assign VSYNC          = vsync_q;
   assign FRAME_RENDERED = frame_q;

endmodule

// File: tb/tb_video_timing.sv
// Directed bench: three reduced-raster instances (CLK_DIV 2, 1, 3) and one
// default-raster instance, checked with immediate assertions.
module tb_video_timing;

   logic clk;
   logic rst;
   logic rst_a;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   logic       tick_a, vis_a, hs_a, vs_a, fr_a;
   logic [9:0] x_a, y_a;
   logic       tick_b, vis_b, hs_b, vs_b, fr_b;
   logic [9:0] x_b, y_b;
   logic       tick_c, vis_c, hs_c, vs_c, fr_c;
   logic [9:0] x_c, y_c;
   logic       tick_d, vis_d, hs_d, vs_d, fr_d;
   logic [9:0] x_d, y_d;

   // Reduced raster: 8+2+3+2 = 15 pixels per line, 6+1+2+1 = 10 lines.
   video_timing #(.CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                  .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)) u_a (
      .CLK(clk), .RESET(rst_a), .PIXEL_TICK(tick_a), .PIXEL_X(x_a), .PIXEL_Y(y_a),
      .VISIBLE(vis_a), .HSYNC(hs_a), .VSYNC(vs_a), .FRAME_RENDERED(fr_a));

   video_timing #(.CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                  .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)) u_b (
      .CLK(clk), .RESET(rst), .PIXEL_TICK(tick_b), .PIXEL_X(x_b), .PIXEL_Y(y_b),
      .VISIBLE(vis_b), .HSYNC(hs_b), .VSYNC(vs_b), .FRAME_RENDERED(fr_b));

   video_timing #(.CLK_DIV(3), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                  .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)) u_c (
      .CLK(clk), .RESET(rst), .PIXEL_TICK(tick_c), .PIXEL_X(x_c), .PIXEL_Y(y_c),
      .VISIBLE(vis_c), .HSYNC(hs_c), .VSYNC(vs_c), .FRAME_RENDERED(fr_c));

   video_timing u_d (
      .CLK(clk), .RESET(rst), .PIXEL_TICK(tick_d), .PIXEL_X(x_d), .PIXEL_Y(y_d),
      .VISIBLE(vis_d), .HSYNC(hs_d), .VSYNC(vs_d), .FRAME_RENDERED(fr_d));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      int np, pulse0, pulse1, pulse2;
      int ticks_a, visticks_a, hslow_a, vslow_a, maxx_a, maxy_a;
      int wraps_b, ticks_c, first_tick_c;
      int fall1_d, fall2_d, hslow_d, nfall_d;
      logic       prev_fr_a, prev_vs_a, prev_tick_c, prev_hs_d;
      logic [9:0] prev_xb, prev_yb, prev_xc;
      int found, k_fr;

      rst   = 1'b1;
      rst_a = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_a_tick", 32'(tick_a), 32'd0);
      chk("rst_a_x", 32'(x_a), 32'd0);
      chk("rst_a_y", 32'(y_a), 32'd0);
      chk("rst_a_vis", 32'(vis_a), 32'd0);
      chk("rst_a_hs", 32'(hs_a), 32'd1);
      chk("rst_a_vs", 32'(vs_a), 32'd1);
      chk("rst_a_fr", 32'(fr_a), 32'd0);
      chk("rst_b_tick", 32'(tick_b), 32'd0);
      chk("rst_b_vis", 32'(vis_b), 32'd0);
      chk("rst_b_fr", 32'(fr_b), 32'd0);
      chk("rst_c_tick", 32'(tick_c), 32'd0);
      chk("rst_c_hs", 32'(hs_c), 32'd1);
      chk("rst_c_vs", 32'(vs_c), 32'd1);
      chk("rst_c_fr", 32'(fr_c), 32'd0);
      chk("rst_d_xy", {12'd0, y_d, x_d}, 32'd0);
      chk("rst_d_flags", {27'd0, tick_d, vis_d, hs_d, vs_d, fr_d}, 32'b00110);
      chk("rst_b_xy", {12'd0, y_b, x_b}, 32'd0);
      chk("rst_c_xy_vis", {11'd0, vis_c, y_c, x_c}, 32'd0);

      rst   = 1'b0;
      rst_a = 1'b0;
      #1;
      chk("b_tick_on_release", 32'(tick_b), 32'd1);
      chk("a_tick_on_release", 32'(tick_a), 32'd0);

      np = 0; pulse0 = -1; pulse1 = -1; pulse2 = -1;
      ticks_a = 0; visticks_a = 0; hslow_a = 0; vslow_a = 0; maxx_a = 0; maxy_a = 0;
      wraps_b = 0; ticks_c = 0; first_tick_c = -1;
      fall1_d = -1; fall2_d = -1; hslow_d = 0; nfall_d = 0;
      prev_fr_a = fr_a; prev_vs_a = vs_a; prev_tick_c = tick_c; prev_hs_d = hs_d;
      prev_xb = x_b; prev_yb = y_b; prev_xc = x_c;

      for (int n = 1; n <= 3000; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (n == 1) begin
            chk("a_vis_first_edge", 32'(vis_a), 32'd1);
            chk("a_tick_first_edge", 32'(tick_a), 32'd1);
            chk("a_x_first_edge", 32'(x_a), 32'd0);
         end
         // instance a: frame strobe position/width and one-frame statistics
         if (fr_a) begin
            if (np == 0) pulse0 = n;
            if (np == 1) pulse1 = n;
            if (np == 2) pulse2 = n;
            np++;
            chk("a_fr_x", 32'(x_a), 32'd0);
            chk("a_fr_y", 32'(y_a), 32'd6);
         end
         if (prev_fr_a) chk("a_fr_width", 32'(fr_a), 32'd0);
         if (np == 1) begin
            ticks_a    += int'(tick_a);
            visticks_a += int'(tick_a && vis_a);
            hslow_a    += int'(!hs_a);
            vslow_a    += int'(!vs_a);
         end
         if (prev_vs_a && !vs_a) begin
            chk("a_vs_fall_x", 32'(x_a), 32'd0);
            chk("a_vs_fall_y", 32'(y_a), 32'd7);
         end
         if (int'(x_a) > maxx_a) maxx_a = int'(x_a);
         if (int'(y_a) > maxy_a) maxy_a = int'(y_a);
         // instance b: full raster wrap
         if (prev_xb == 10'd14 && prev_yb == 10'd9) begin
            wraps_b++;
            chk("b_wrap_xy", {12'd0, y_b, x_b}, 32'd0);
            chk("b_wrap_vs", 32'(vs_b), 32'd1);
            chk("b_wrap_vis", 32'(vis_b), 32'd1);
         end
         // instance c: tick spacing and hold between ticks
         if (tick_c) begin
            ticks_c++;
            if (first_tick_c < 0) first_tick_c = n;
         end
         if (!prev_tick_c) chk("c_x_hold", 32'(x_c), 32'(prev_xc));
         // instance d: default raster hsync edges
         if (prev_hs_d && !hs_d) begin
            nfall_d++;
            if (nfall_d == 1) fall1_d = n;
            if (nfall_d == 2) fall2_d = n;
            chk("d_hs_fall_x", 32'(x_d), 32'd656);
         end
         if (!prev_hs_d && hs_d) chk("d_hs_rise_x", 32'(x_d), 32'd752);
         if (nfall_d == 1 && !hs_d) hslow_d++;
         prev_fr_a = fr_a; prev_vs_a = vs_a; prev_tick_c = tick_c; prev_hs_d = hs_d;
         prev_xb = x_b; prev_yb = y_b; prev_xc = x_c;
      end

      chk("a_first_pulse_cycle", 32'(pulse0), 32'd180);
      chk("a_frame_period_1", 32'(pulse1 - pulse0), 32'd300);
      chk("a_frame_period_2", 32'(pulse2 - pulse1), 32'd300);
      chk("a_pulse_count", 32'(np), 32'd10);
      chk("a_ticks_per_frame", 32'(ticks_a), 32'd150);
      chk("a_visible_ticks", 32'(visticks_a), 32'd48);
      chk("a_hsync_low_cycles", 32'(hslow_a), 32'd60);
      chk("a_vsync_low_cycles", 32'(vslow_a), 32'd60);
      chk("a_max_x", 32'(maxx_a), 32'd14);
      chk("a_max_y", 32'(maxy_a), 32'd9);
      chk("b_wrap_count", 32'(wraps_b), 32'd20);
      chk("c_first_tick_cycle", 32'(first_tick_c), 32'd2);
      chk("c_tick_count", 32'(ticks_c), 32'd1000);
      chk("d_first_hs_fall", 32'(fall1_d), 32'd1312);
      chk("d_line_period", 32'(fall2_d - fall1_d), 32'd1600);
      chk("d_hsync_low_cycles", 32'(hslow_d), 32'd192);

      // Mid-frame reset of instance a
      found = 0;
      for (int k = 0; k < 400; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (y_a == 10'd3) begin
            found = 1;
            break;
         end
      end
      chk("a_reach_y3", 32'(found), 32'd1);
      rst_a = 1'b1;
      #1;
      chk("a_async_rst_xy", {12'd0, y_a, x_a}, 32'd0);
      chk("a_async_rst_flags", {27'd0, tick_a, vis_a, hs_a, vs_a, fr_a}, 32'b00110);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk("a_in_rst_xy", {12'd0, y_a, x_a}, 32'd0);
         chk("a_in_rst_flags", {27'd0, tick_a, vis_a, hs_a, vs_a, fr_a}, 32'b00110);
      end
      rst_a = 1'b0;
      k_fr = -1;
      for (int k = 1; k <= 400; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (fr_a) begin
            k_fr = k;
            break;
         end
      end
      chk("a_fr_after_reset", 32'(k_fr), 32'd180);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
